// File: rtl/anc_pkg.sv
// Shared widths and signed full-scale helpers for the anti-noise datapath.
// Consumers: anc_sat_negate, anc_negate_pipe (and the later gain stage).
package anc_pkg;

   localparam int ANC_DATA_W = 64;
   localparam int ANC_CH_W   = 2;

   // Widest sample any consumer may request from the helpers below.
   localparam int ANC_MAX_W  = 256;

   function automatic logic [ANC_MAX_W-1:0] anc_fs_max(input int unsigned w);
      return {ANC_MAX_W{1'b1}} >> (ANC_MAX_W - w + 1);
   endfunction

   function automatic logic [ANC_MAX_W-1:0] anc_fs_min(input int unsigned w);
      return {{(ANC_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
   endfunction

endpackage

// File: rtl/anc_sat_negate.sv
// Combinational conditional negate with clamp to positive full scale.
// The only overflow is negating the most negative value.
module anc_sat_negate
   import anc_pkg::*;
#(
   parameter int DATA_W = ANC_DATA_W
) (
   input  logic [DATA_W-1:0] data,
   input  logic              inv_bit,
   output logic [DATA_W-1:0] result,
   output logic              sat
);

   localparam logic [ANC_MAX_W-1:0] FS_MAX_FULL = anc_fs_max(DATA_W);
   localparam logic [DATA_W-1:0]    FS_MAX      = FS_MAX_FULL[DATA_W-1:0];

   logic [DATA_W:0] neg_s;

   // One extra bit of headroom so the negation itself cannot wrap.
   always_comb begin
      neg_s = {(DATA_W+1){1'b0}} - {data[DATA_W-1], data};
   end

   // Select pass-through, negation, or clamp when the top two bits disagree.
   always_comb begin
      result = data;
      sat    = 1'b0;
      if (inv_bit) begin
         if (neg_s[DATA_W] != neg_s[DATA_W-1]) begin
            result = FS_MAX;
            sat    = 1'b1;
         end else begin
            result = neg_s[DATA_W-1:0];
            sat    = 1'b0;
         end
      end else begin
         result = data;
         sat    = 1'b0;
      end
   end

endmodule

// File: rtl/anc_negate_pipe.sv
// Two-stage valid/ready per-channel negator for the anti-noise path.
// Optional saturation event counter: define ANC_NEGATE_SATCNT_EN.
module anc_negate_pipe
   import anc_pkg::*;
#(
   parameter int DATA_W   = ANC_DATA_W,
   parameter int NUM_CH   = 4,
   parameter int CH_W     = ANC_CH_W,
   parameter int SATCNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_CH-1:0]   inv_mask,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DATA_W-1:0]   s_data,
   input  logic [CH_W-1:0]     s_ch,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [DATA_W-1:0]   m_data,
   output logic [CH_W-1:0]     m_ch,
   output logic                m_sat,
   output logic [SATCNT_W-1:0] sat_cnt,
   input  logic                sat_cnt_clr
);

   localparam int TAG_N = 2 ** CH_W;

   logic              v1_r;
   logic [DATA_W-1:0] d1_r;
   logic [CH_W-1:0]   ch1_r;
   logic              inv1_r;
   logic              v2_r;
   logic [DATA_W-1:0] d2_r;
   logic [CH_W-1:0]   ch2_r;
   logic              sat2_r;

   logic              load1_s;
   logic              load2_s;
   logic [TAG_N-1:0]  mask_ext_s;
   logic              inv_s;
   logic [DATA_W-1:0] res_s;
   logic              sat_s;

   // Stage load enables; s_ready depends only on state and m_ready.
   always_comb begin
      load2_s = !v2_r || m_ready;
      load1_s = !v1_r || load2_s;
   end

   assign s_ready = load1_s;

   // Unused tag codes read as zero, so out-of-range channels pass through.
   always_comb begin
      mask_ext_s               = {TAG_N{1'b0}};
      mask_ext_s[NUM_CH-1:0]   = inv_mask;
      inv_s                    = mask_ext_s[s_ch];
   end

   // S1: capture sample, tag and the invert decision at acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_r   <= 1'b0;
         d1_r   <= {DATA_W{1'b0}};
         ch1_r  <= {CH_W{1'b0}};
         inv1_r <= 1'b0;
      end else if (load1_s) begin
         v1_r <= s_valid;
         if (s_valid) begin
            d1_r   <= s_data;
            ch1_r  <= s_ch;
            inv1_r <= inv_s;
         end
      end
   end

   anc_sat_negate #(
      .DATA_W (DATA_W)
   ) u_sat_negate (
      .data    (d1_r),
      .inv_bit (inv1_r),
      .result  (res_s),
      .sat     (sat_s)
   );

   // S2: registered result; holds while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_r   <= 1'b0;
         d2_r   <= {DATA_W{1'b0}};
         ch2_r  <= {CH_W{1'b0}};
         sat2_r <= 1'b0;
      end else if (load2_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            d2_r   <= res_s;
            ch2_r  <= ch1_r;
            sat2_r <= sat_s;
         end
      end
   end

   assign m_valid = v2_r;
   assign m_data  = d2_r;
   assign m_ch    = ch2_r;
   assign m_sat   = sat2_r;

`ifdef ANC_NEGATE_SATCNT_EN
   logic [SATCNT_W-1:0] sat_cnt_r;

   // Count transferred saturated samples; sticks at all-ones, clear has priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt_r <= {SATCNT_W{1'b0}};
      end else if (sat_cnt_clr) begin
         sat_cnt_r <= {SATCNT_W{1'b0}};
      end else if (v2_r && m_ready && sat2_r && (sat_cnt_r != {SATCNT_W{1'b1}})) begin
         sat_cnt_r <= sat_cnt_r + {{(SATCNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign sat_cnt = sat_cnt_r;
`else
   logic unused_sat_cnt_clr_s;

   assign unused_sat_cnt_clr_s = sat_cnt_clr;
   assign sat_cnt              = {SATCNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_anc_negate_pipe.sv
// Directed self-checking bench for anc_negate_pipe (default parameters).
module tb_anc_negate_pipe;

   logic        clk;
   logic        rst_n;
   logic [3:0]  inv_mask;
   logic        s_valid;
   logic        s_ready;
   logic [63:0] s_data;
   logic [1:0]  s_ch;
   logic        m_valid;
   logic        m_ready;
   logic [63:0] m_data;
   logic [1:0]  m_ch;
   logic        m_sat;
   logic [15:0] sat_cnt;
   logic        sat_cnt_clr;

`ifdef ANC_NEGATE_SATCNT_EN
   localparam logic [15:0] CNT_ONE = 16'd1;
`else
   localparam logic [15:0] CNT_ONE = 16'd0;
`endif

   localparam logic [63:0] FS_MIN = 64'h8000_0000_0000_0000;
   localparam logic [63:0] FS_MAX = 64'h7FFF_FFFF_FFFF_FFFF;

   int n_cmp  = 0;
   int n_fail = 0;

   anc_negate_pipe dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .inv_mask    (inv_mask),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_ch        (s_ch),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_ch        (m_ch),
      .m_sat       (m_sat),
      .sat_cnt     (sat_cnt),
      .sat_cnt_clr (sat_cnt_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  ch;
      logic [63:0] data;
      logic [3:0]  mask;
      logic [63:0] exp_data;
      logic        exp_sat;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs[NV];

   logic [31:0] ready_pat;
   logic [63:0] sdat[8];
   logic [63:0] exp_d;
   logic [63:0] held_d;
   logic [1:0]  held_c;
   logic        stalled;
   logic        acc;
   logic        xfer;
   int          sent;
   int          got;
   int          occ;

   initial begin
      vecs[0] = '{2'd0, 64'd5,                     4'b1111, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0};
      vecs[1] = '{2'd1, FS_MIN,                    4'b1111, FS_MAX,                  1'b1};
      vecs[2] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFF9,   4'b0101, 64'd7,                   1'b0};
      vecs[3] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFF9,   4'b0101, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0};
      vecs[4] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFF9,   4'b0101, 64'd7,                   1'b0};
      vecs[5] = '{2'd3, 64'hFFFF_FFFF_FFFF_FFF9,   4'b0101, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0};
      vecs[6] = '{2'd2, FS_MAX,                    4'b1111, 64'h8000_0000_0000_0001, 1'b0};
      vecs[7] = '{2'd3, 64'd0,                     4'b1111, 64'd0,                   1'b0};
      vecs[8] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF,   4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

      rst_n       = 1'b0;
      inv_mask    = 4'b0000;
      s_valid     = 1'b0;
      s_data      = 64'd0;
      s_ch        = 2'd0;
      m_ready     = 1'b1;
      sat_cnt_clr = 1'b0;

      // Reset state
      #12;
      chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
      chk("rst_m_data",  m_data, 64'd0);
      chk("rst_m_ch",    {62'd0, m_ch}, 64'd0);
      chk("rst_m_sat",   {63'd0, m_sat}, 64'd0);
      chk("rst_sat_cnt", {48'd0, sat_cnt}, 64'd0);
      chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
      rst_n = 1'b1;
      step();

      // Table: back-to-back stream, each result must appear exactly 2 edges later
      for (int i = 0; i <= NV; i++) begin
         if (i < NV) begin
            s_valid  = 1'b1;
            s_ch     = vecs[i].ch;
            s_data   = vecs[i].data;
            inv_mask = vecs[i].mask;
         end else begin
            s_valid = 1'b0;
         end
         step();
         if (i >= 1) begin
            chk($sformatf("tbl%0d_valid", i-1), {63'd0, m_valid}, 64'd1);
            chk($sformatf("tbl%0d_data",  i-1), m_data, vecs[i-1].exp_data);
            chk($sformatf("tbl%0d_ch",    i-1), {62'd0, m_ch}, {62'd0, vecs[i-1].ch});
            chk($sformatf("tbl%0d_sat",   i-1), {63'd0, m_sat}, {63'd0, vecs[i-1].exp_sat});
         end
      end
      step();
      chk("tbl_drained", {63'd0, m_valid}, 64'd0);
      chk("tbl_sat_cnt", {48'd0, sat_cnt}, {48'd0, CNT_ONE});

      // inv_mask change while a ch0 sample sits in S1
      inv_mask = 4'b0001;
      s_valid  = 1'b1;
      s_ch     = 2'd0;
      s_data   = 64'd9;
      step();
      inv_mask = 4'b0000;
      step();
      s_valid = 1'b0;
      chk("mask_old_data", m_data, 64'hFFFF_FFFF_FFFF_FFF7);
      step();
      chk("mask_new_data", m_data, 64'd9);
      step();

      // Random-looking backpressure over 8 samples
      ready_pat = 32'hB53C_96E1;
      inv_mask  = 4'b0011;
      for (int i = 0; i < 8; i++) sdat[i] = 64'h100 + 64'(i) * 64'd3;
      sent = 0; got = 0; occ = 0; stalled = 1'b0;
      for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
         m_ready = ready_pat[cyc % 32];
         s_valid = (sent < 8);
         if (sent < 8) begin
            s_ch   = 2'(sent % 4);
            s_data = sdat[sent];
         end
         #2;
         chk("stall_s_ready", {63'd0, s_ready}, {63'd0, !(occ == 2 && !m_ready)});
         if (stalled) begin
            chk("stall_hold_valid", {63'd0, m_valid}, 64'd1);
            chk("stall_hold_data",  m_data, held_d);
            chk("stall_hold_ch",    {62'd0, m_ch}, {62'd0, held_c});
         end
         acc  = s_valid && s_ready;
         xfer = m_valid && m_ready;
         if (xfer) begin
            exp_d = ((got % 4) < 2) ? (64'd0 - sdat[got]) : sdat[got];
            chk($sformatf("stall%0d_ch", got),   {62'd0, m_ch}, 64'(got % 4));
            chk($sformatf("stall%0d_data", got), m_data, exp_d);
            chk($sformatf("stall%0d_sat", got),  {63'd0, m_sat}, 64'd0);
            got++;
         end
         stalled = m_valid && !m_ready;
         held_d  = m_data;
         held_c  = m_ch;
         if (acc)  occ++;
         if (acc)  sent++;
         if (xfer) occ--;
         step();
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      chk("stall_count", 64'(got), 64'd8);
      step();
      step();
      chk("stall_no_dup", {63'd0, m_valid}, 64'd0);

      // Reset with both stages full
      m_ready  = 1'b0;
      inv_mask = 4'b0001;
      s_valid  = 1'b1;
      s_ch     = 2'd0;
      s_data   = 64'd11;
      step();
      s_data = 64'd12;
      step();
      s_valid = 1'b0;
      chk("full_m_valid", {63'd0, m_valid}, 64'd1);
      chk("full_s_ready", {63'd0, s_ready}, 64'd0);
      chk("full_m_data",  m_data, 64'hFFFF_FFFF_FFFF_FFF5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_m_valid", {63'd0, m_valid}, 64'd0);
      chk("arst_m_data",  m_data, 64'd0);
      chk("arst_sat_cnt", {48'd0, sat_cnt}, 64'd0);
      #3;
      rst_n   = 1'b1;
      m_ready = 1'b1;
      step();
      chk("post_rst_empty", {63'd0, m_valid}, 64'd0);
      s_valid = 1'b1;
      s_data  = 64'd3;
      step();
      s_valid = 1'b0;
      chk("post_rst_lat1", {63'd0, m_valid}, 64'd0);
      step();
      chk("post_rst_lat2", {63'd0, m_valid}, 64'd1);
      chk("post_rst_data", m_data, 64'hFFFF_FFFF_FFFF_FFFD);
      step();

      // Clear wins over a same-cycle saturating transfer
      inv_mask = 4'b1111;
      s_valid  = 1'b1;
      s_ch     = 2'd2;
      s_data   = FS_MIN;
      step();
      s_valid = 1'b0;
      step();
      chk("clr_m_sat", {63'd0, m_sat}, 64'd1);
      sat_cnt_clr = 1'b1;
      step();
      sat_cnt_clr = 1'b0;
      chk("clr_sat_cnt", {48'd0, sat_cnt}, 64'd0);

      // Increment without clear
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      step();
      chk("inc_m_data", m_data, FS_MAX);
      step();
      chk("inc_sat_cnt", {48'd0, sat_cnt}, {48'd0, CNT_ONE});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/anc_negate_pipe.md
Name: anc_negate_pipe

Overview:
- Parametrised, pipelined successor to the fixed 64-bit combinational negator in the anti-noise path.
- Takes tagged multi-channel signed samples over a valid/ready stream.
- Per channel, either inverts the sample (anti-noise) or passes it through, with saturation on the single overflow case.
- Sits between the noise-estimate filter output and the DAC drive mixer.

Parameters:
- DATA_W, 64, signed sample width in bits (>=2)
- NUM_CH, 4, number of channels (>=1)
- CH_W, 2, channel tag width; must satisfy 2**CH_W >= NUM_CH
- SATCNT_W, 16, width of the saturation event counter (optional feature)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- inv_mask  in  NUM_CH  per-channel invert enable; 1=negate, 0=pass-through; sampled at input acceptance
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept input
- s_data  in  DATA_W  signed input sample
- s_ch  in  CH_W  input channel tag
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts output
- m_data  out  DATA_W  signed result
- m_ch  out  CH_W  channel tag, passed through unchanged
- m_sat  out  1  result was saturated
- sat_cnt  out  SATCNT_W  saturation event count (SATCNT_EN only; else tied 0)
- sat_cnt_clr  in  1  synchronous clear of sat_cnt (ignored without SATCNT_EN)

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - v1, v2, m_valid = 0
  - m_data, m_ch, m_sat = 0; all stage registers = 0; sat_cnt = 0
- Two register stages, S1 and S2. Latency is exactly 2 cycles from acceptance to m_valid when m_ready is held high.
- Throughput is 1 sample/cycle.
- Handshake:
  - Input accepted when s_valid && s_ready.
  - Output transferred when m_valid && m_ready.
  - s_ready = !v1 || !v2 || m_ready (combinational; no combinational path from s_valid to s_ready).
  - S2 loads when !v2 || m_ready.
  - S1 loads when !v1 || S2 loads.
- While m_valid && !m_ready, m_data/m_ch/m_sat stay stable. An upstream stall never drops or duplicates a sample.
- S1 captures: s_data, s_ch, inv_bit = inv_mask[s_ch].
  - If s_ch >= NUM_CH, inv_bit = 0 (pass-through); the tag is still forwarded.
- S2 computes:
  - If inv_bit = 0: result = data; m_sat = 0.
  - If inv_bit = 1 and data == -2^(DATA_W-1): result = 2^(DATA_W-1)-1 (positive full scale); m_sat = 1.
  - Otherwise: result = two's-complement negation; m_sat = 0.
  - Negation uses DATA_W+1-bit intermediate, then clamps; never wraps.
- inv_mask changes affect only samples accepted after the change; samples in flight keep their captured inv_bit.
- Reset asserted mid-stream: all in-flight samples are discarded, outputs are 0 immediately (asynchronous).
- Simultaneous transfer in and out with both stages full: the pipeline advances, occupancy stays 2.

Optional Feature:
- Macro: ANC_NEGATE_SATCNT_EN
- Defined:
  - sat_cnt increments by 1 on each output transfer with m_sat=1.
  - It saturates at all-ones (no wrap).
  - sat_cnt_clr=1 forces 0 on the next edge; clear wins over a same-cycle increment.
- Undefined:
  - No counter register exists; sat_cnt is driven constant 0; sat_cnt_clr is unused.
  - Datapath behaviour is identical.

Decomposition:
- Shared package anc_pkg:
  - localparam helpers for signed full-scale max/min as functions of width
  - default widths ANC_DATA_W=64 and ANC_CH_W=2
- One sub-module: anc_sat_negate, purely combinational (data, inv_bit -> result, sat).
  - Reused later by the gain stage; instanced in S2.
- Pipeline registers and handshake stay in the top module.

Test Plan:
- DATA_W=64, inv_mask=4'b1111, m_ready=1, feed ch0 data=5 -> m_data=-5, m_sat=0, exactly 2 cycles after acceptance.
- Feed ch1 data=0x8000_0000_0000_0000 with invert -> m_data=0x7FFF_FFFF_FFFF_FFFF, m_sat=1; sat_cnt=1 with macro defined, 0 without.
- inv_mask=4'b0101, stream ch0..ch3 all data=-7 -> outputs 7,-7,7,-7; m_ch=0,1,2,3 in order.
- Stream 8 samples, m_ready toggled pseudo-randomly -> all 8 emerge in order, no loss/duplication, m_data stable while stalled; s_ready=0 only when both stages full and m_ready=0.
- Change inv_mask 1->0 for ch0 while a ch0 sample is in S1 -> that sample is still negated; the next ch0 sample passes through.
- Assert rst_n=0 with both stages valid -> m_valid=0, m_data=0 immediately; after release, the first accepted sample appears 2 cycles later; sat_cnt_clr with concurrent saturating output -> sat_cnt=0.
